paralelo_serial2: RTL and testbench

PARALELO_SERIAL2 -- requirements
Module: paralelo_serial2

---
 rtl/paralelo_serial2_pkg.sv | 21 ++
 rtl/tx_hold_buffer.sv | 38 +++
 rtl/paralelo_serial2.sv | 105 ++++++++++
 tb/tb_paralelo_serial2.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/paralelo_serial2_pkg.sv
// Shared constants, state type and helpers for the paralelo_serial2 serializer.
package paralelo_serial2_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned CNT_W          = 3;
    localparam int unsigned SYNC_COUNT_DEF = 4;

    localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;
    localparam logic [BYTE_W-1:0] IDLE_BYTE  = 8'h7C;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Last bit slot of a byte: the shift register reloads on this edge.
    function automatic logic is_boundary(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_W'(BYTE_W - 1));
    endfunction

endpackage

// File: rtl/tx_hold_buffer.sv
// One-entry holding register between the parallel producer and the serializer.
module tx_hold_buffer
    import paralelo_serial2_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_pop,
    output logic              o_ready,
    output logic              o_full,
    output logic [BYTE_W-1:0] o_data
);

    logic              r_full;
    logic [BYTE_W-1:0] r_data;
    logic              w_accept;

    // Pop only happens while full and accept only while empty, so they never collide.
    assign w_accept = i_valid & ~r_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_pop) begin
            r_full <= 1'b0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end
    end

    assign o_ready = ~r_full;
    assign o_full  = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/paralelo_serial2.sv
// Byte-to-serial transmitter: sends SYNC_COUNT commas after reset, then data
// bytes from a one-entry holding register, filling gaps with idle bytes.
module paralelo_serial2
    import paralelo_serial2_pkg::*;
#(
    parameter int unsigned SYNC_COUNT = SYNC_COUNT_DEF
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic [BYTE_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              data_out,
    output logic              byte_sync,
    output logic              tx_active
);

    localparam logic [CNT_W-1:0] SYNC_LIMIT = CNT_W'(SYNC_COUNT);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  r_sync_cnt;
    logic [BYTE_W-1:0] r_shreg;
    logic              r_byte_sync;

    logic              w_boundary;
    logic              w_comma_due;
    logic [BYTE_W-1:0] w_load_byte;
    logic              w_hold_pop;
    logic              w_sync_inc;
    logic              w_hold_full;
    logic [BYTE_W-1:0] w_hold_data;

    assign w_boundary  = is_boundary(r_bit_cnt);
    assign w_comma_due = (r_state == ST_SYNC) && (r_sync_cnt < SYNC_LIMIT);

    tx_hold_buffer u_hold (
        .clk     (clk_32f),
        .rst     (reset),
        .i_data  (data_in),
        .i_valid (valid_in),
        .i_pop   (w_hold_pop),
        .o_ready (ready_out),
        .o_full  (w_hold_full),
        .o_data  (w_hold_data)
    );

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ACTIVE is absorbing; only reset returns to SYNC.
    always_comb begin
        w_next_state = r_state;
        if ((r_state == ST_SYNC) && w_boundary && !w_comma_due) begin
            w_next_state = ST_ACTIVE;
        end
    end

    // Byte selection at a boundary; the SYNC->ACTIVE edge already serves data/idle.
    always_comb begin
        w_load_byte = IDLE_BYTE;
        w_hold_pop  = 1'b0;
        w_sync_inc  = 1'b0;
        if (w_boundary) begin
            if (w_comma_due) begin
                w_load_byte = COMMA_BYTE;
                w_sync_inc  = 1'b1;
            end else if (w_hold_full) begin
                w_load_byte = w_hold_data;
                w_hold_pop  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_shreg     <= COMMA_BYTE;
            r_sync_cnt  <= CNT_W'(1);
            r_byte_sync <= 1'b1;
        end else begin
            r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
            r_byte_sync <= w_boundary;
            if (w_boundary) begin
                r_shreg <= w_load_byte;
            end else begin
                r_shreg <= {1'b0, r_shreg[BYTE_W-1:1]};
            end
            if (w_sync_inc) begin
                r_sync_cnt <= r_sync_cnt + CNT_W'(1);
            end
        end
    end

    assign data_out  = r_shreg[0];
    assign byte_sync = r_byte_sync;
    assign tx_active = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_paralelo_serial2.sv
// Self-checking bench for paralelo_serial2 against a slot-level stream model.
module tb_paralelo_serial2;

    localparam int SYNC = 4;

    logic       clk_32f  = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       byte_sync;
    logic       tx_active;

    paralelo_serial2 #(.SYNC_COUNT(SYNC)) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .byte_sync (byte_sync),
        .tx_active (tx_active)
    );

    always #5 clk_32f = ~clk_32f;

    int total = 0;
    int bad   = 0;
    int t     = 0;             // edges since reset release
    logic [7:0] slot_q[$];     // bytes of slots SYNC, SYNC+1, ...
    logic [7:0] hold_q[$];     // at most one waiting byte

    function automatic logic [7:0] exp_byte(input int s);
        if (s < SYNC) return 8'hBC;
        if ((s - SYNC) < slot_q.size()) return slot_q[s - SYNC];
        return 8'h00;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int s;
        int b;
        logic [7:0] eb;
        s  = t / 8;
        b  = t % 8;
        eb = exp_byte(s);
        chk("data_out",  data_out,  eb[b]);
        chk("byte_sync", byte_sync, (b == 0));
        chk("tx_active", tx_active, (s >= SYNC));
        chk("ready_out", ready_out, (hold_q.size() == 0));
    endtask

    // Each byte slot is 8 edges; slot contents decided when the slot starts.
    task automatic model_edge(input logic v, input logic [7:0] d);
        bit was_empty;
        int tn;
        was_empty = (hold_q.size() == 0);
        tn = t + 1;
        if ((tn % 8 == 0) && (tn / 8 >= SYNC)) begin
            if (hold_q.size() > 0) slot_q.push_back(hold_q.pop_front());
            else                   slot_q.push_back(8'h7C);
        end
        if (v && was_empty) hold_q.push_back(d);
        t = tn;
    endtask

    task automatic model_reset();
        t = 0;
        slot_q.delete();
        hold_q.delete();
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk_32f);
        model_edge(v, d);
        @(negedge clk_32f);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    // Hold valid_in with d until the byte is taken; leaves valid_in asserted.
    task automatic offer(input logic [7:0] d);
        bit taken;
        taken = 1'b0;
        for (int i = 0; i < 64 && !taken; i++) begin
            taken = (hold_q.size() == 0);
            tick(1'b1, d);
        end
        total++;
        if (!taken) begin
            bad++;
            $error("FAIL offer_timeout data=%h observed=not_taken expected=taken", d);
        end
    endtask

    // Reset asserted between clock edges; outputs must change without an edge.
    task automatic async_reset();
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk_32f);
        @(negedge clk_32f);
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_32f);
        model_reset();
        check_outputs();
        reset = 1'b0;

        // Commas then idle bytes with no traffic
        idle(48);

        // Byte offered during SYNC waits for the end of the comma sequence
        async_reset();
        idle(5);
        offer(8'hA5);
        idle(40);

        // Back-to-back bytes with valid held
        offer(8'h11);
        offer(8'h22);
        idle(30);

        // Offer landing exactly on a boundary edge with the holder empty
        for (int i = 0; i < 8 && ((t + 1) % 8 != 0); i++) tick(1'b0, 8'h00);
        tick(1'b1, 8'h3C);
        idle(20);

        // Comma/idle values as data pass through unchanged
        offer(8'hBC);
        offer(8'h7C);
        idle(24);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 3) == 0), 8'($urandom));
        end
        idle(16);

        // Reset at bit 3 of a data byte with another byte held
        offer(8'h55);
        offer(8'h66);
        for (int i = 0; i < 8 && (t % 8 != 3); i++) tick(1'b0, 8'h00);
        async_reset();
        idle(48);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
